// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   fetch_entry_t : one fetched word tagged with its PC
//   INST_BYTES    : PC increment per instruction
//   NOP_INST      : canonical no-op encoding (addi x0, x0, 0)
//   align_pc()    : clears the byte-offset bits of a PC
package fetch_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'(INST_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer queue of fetched entries with synchronous flush and a
// zero-latency head (head_o reflects the oldest entry combinationally).
//   clk, rst   : clock, async active-high reset
//   flush_i    : empty the queue this cycle (overrides push and pop)
//   push_i     : write data_i at the tail
//   pop_i      : drop the head entry (ignored when empty)
//   head_o     : oldest entry
//   count_o    : number of valid entries, 0..DEPTH
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   data_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Credit accounting upstream must never let a response land in a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, buffers returned
// words with their PCs, hands them to decode and restarts on redirect.
//   clk, rst                         : clock, async active-high reset
//   imem_req_valid/ready/addr        : fetch request channel
//   imem_resp_valid/data             : in-order read responses
//   redirect_valid/pc                : one-cycle restart pulse and target
//   inst_valid/ready, inst_out/pc_out: decode handshake and payload
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count;
  logic          has_credit;
  logic          req_fire;
  logic          push;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Queue slots are reserved at request time, so buffered plus outstanding stays within DEPTH.
  assign has_credit     = (SW'(count) + SW'(inflight_q)) < SW'(DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && has_credit;
  assign imem_req_addr  = req_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses owed to a squashed stream are swallowed while drop_cnt is nonzero.
  assign push       = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign push_entry = '{pc: resp_pc_q, inst: imem_resp_data};

  // PC, credit and drop counter next state; redirect overrides normal advance.
  always_comb begin
    req_pc_d   = req_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    inflight_d = inflight_q;
    if (req_fire)        inflight_d = inflight_d + CW'(1);
    if (imem_resp_valid) inflight_d = inflight_d - CW'(1);
    if (redirect_valid) begin
      req_pc_d   = align_pc(redirect_pc);
      resp_pc_d  = align_pc(redirect_pc);
      drop_cnt_d = inflight_d;
    end else begin
      if (req_fire) req_pc_d = req_pc_q + 32'(INST_BYTES);
      if (imem_resp_valid) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
        else                  resp_pc_d  = resp_pc_q + 32'(INST_BYTES);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q   <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      req_pc_q   <= req_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (inst_ready),
    .head_o  (head),
    .count_o (count)
  );

  // Payload is zeroed when empty so stale storage never leaks to decode.
  assign inst_valid = (count != '0);
  assign inst_out   = inst_valid ? head.inst : '0;
  assign pc_out     = inst_valid ? head.pc   : '0;

endmodule
